// File: rtl/timing_gen.sv
// Beat (W1..W3) and phase (T1..T3) generator for the hardwired controller.
// Optional single-beat stepping input STEP is compiled in with `define TIMING_STEP_EN.
module timing_gen #(
  parameter int PHASES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             QD,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
`ifdef TIMING_STEP_EN
  input  logic             STEP,
`endif
  output logic [3:1]       W,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             RUN,
  output logic [CNT_W-1:0] BEATS
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] P_LAST = PW'(PHASES - 1);

  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [3:1]       w_q, w_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             q1_q, q2_q, q3_q;
  logic             start;
  logic             stop_eff;
  logic             w_legal;
  logic [3:1]       w_adv;

`ifdef TIMING_STEP_EN
  assign stop_eff = STOP | STEP;
`else
  assign stop_eff = STOP;
`endif

  assign start   = q2_q & ~q3_q;
  assign w_legal = (w_q == 3'b001) || (w_q == 3'b010) || (w_q == 3'b100);

  // SHORT only matters in W1 and LONG only in W2; SHORT takes priority in W1.
  always_comb begin
    w_adv = 3'b001;
    case (w_q)
      3'b001:  w_adv = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_adv = LONG  ? 3'b100 : 3'b001;
      default: w_adv = 3'b001;
    endcase
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    w_d     = w_q;
    beats_d = beats_q;
    case (state_q)
      S_HALT: begin
        p_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (p_q == P_LAST) begin
          p_d     = '0;
          beats_d = beats_q + 1'b1;
          w_d     = w_adv;
          if (stop_eff) state_d = S_HALT;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
    if (!w_legal) w_d = 3'b001;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_HALT;
      p_q     <= '0;
      w_q     <= 3'b001;
      beats_q <= '0;
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
      q3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      w_q     <= w_d;
      beats_q <= beats_d;
      q1_q    <= QD;
      q2_q    <= q1_q;
      q3_q    <= q2_q;
    end
  end

  assign RUN   = (state_q == S_RUN);
  assign W     = w_q;
  assign BEATS = beats_q;
  assign T1    = RUN && (p_q == '0);
  assign T3    = RUN && (p_q == P_LAST);
  assign T2    = RUN && (p_q != '0) && (p_q != P_LAST);

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: cycle model feeds a scoreboard queue, plus fixed-value checkpoints.
module tb_timing_gen;

  localparam int PHASES = 3;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic             run;
    logic [3:1]       w;
    logic             t1;
    logic             t2;
    logic             t3;
    logic [CNT_W-1:0] beats;
  } obs_t;

  logic             clk;
  logic             clr, qd, sh, lg, stp;
  logic [3:1]       w;
  logic             t1, t2, t3, run;
  logic [CNT_W-1:0] beats;
`ifdef TIMING_STEP_EN
  logic             step;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  obs_t sb_q[$];

  // reference model state
  logic             m_run, m_q1, m_q2, m_q3;
  logic [3:1]       m_w;
  int               m_p;
  logic [CNT_W-1:0] m_beats;

  timing_gen #(.PHASES(PHASES), .CNT_W(CNT_W)) dut (
    .CLK(clk), .CLR(clr), .QD(qd), .SHORT(sh), .LONG(lg), .STOP(stp),
`ifdef TIMING_STEP_EN
    .STEP(step),
`endif
    .W(w), .T1(t1), .T2(t2), .T3(t3), .RUN(run), .BEATS(beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    obs_t e, got;
    logic start_m, halt_m;
    start_m = m_q2 & ~m_q3;
    halt_m  = stp;
`ifdef TIMING_STEP_EN
    halt_m  = stp | step;
`endif
    if (clr) begin
      m_run = 1'b0; m_w = 3'b001; m_p = 0; m_beats = '0;
      m_q1 = 1'b0; m_q2 = 1'b0; m_q3 = 1'b0;
    end else begin
      m_q3 = m_q2; m_q2 = m_q1; m_q1 = qd;
      if (!m_run) begin
        if (start_m) begin m_run = 1'b1; m_p = 0; end
      end else if (m_p == PHASES - 1) begin
        m_p = 0;
        m_beats = m_beats + 1'b1;
        if (m_w == 3'b001)      m_w = sh ? 3'b001 : 3'b010;
        else if (m_w == 3'b010) m_w = lg ? 3'b100 : 3'b001;
        else                    m_w = 3'b001;
        if (halt_m) m_run = 1'b0;
      end else begin
        m_p = m_p + 1;
      end
    end
    e.run   = m_run;
    e.w     = m_w;
    e.t1    = m_run && (m_p == 0);
    e.t2    = m_run && (m_p > 0) && (m_p < PHASES - 1);
    e.t3    = m_run && (m_p == PHASES - 1);
    e.beats = m_beats;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = {run, w, t1, t2, t3, beats};
    e = sb_q.pop_front();
    check("sb", 32'(got), 32'(e));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_run = 1'b0; m_w = 3'b001; m_p = 0; m_beats = '0;
    m_q1 = 1'b0; m_q2 = 1'b0; m_q3 = 1'b0;
    clr = 1'b1; qd = 1'b0; sh = 1'b0; lg = 1'b0; stp = 1'b0;
`ifdef TIMING_STEP_EN
    step = 1'b0;
`endif
    // reset and start latency
    ticks(2);
    check("rst_state", 32'({run, w, t1, t2, t3}), 32'(7'b0_001_000));
    check("rst_beats", 32'(beats), 32'd0);
    clr = 1'b0;
    ticks(2);
    qd = 1'b1;
    tick();
    check("halt_e5", 32'({run, w}), 32'(4'b0_001));
    tick();
    check("halt_e6", 32'({run, w, t1}), 32'(5'b0_001_0));
    tick();
    check("start_t1", 32'({run, t1, t2, t3}), 32'(4'b1100));
    tick();
    check("start_t2", 32'({run, t1, t2, t3}), 32'(4'b1010));
    tick();
    check("start_t3", 32'({run, t1, t2, t3}), 32'(4'b1001));
    tick();
    check("w2_e10", 32'({w, t1}), 32'(4'b010_1));
    qd = 1'b0;
    // plain two-beat loop
    ticks(3); check("loop_w1", 32'(w), 32'(3'b001));
    ticks(3); check("loop_w2", 32'(w), 32'(3'b010));
    ticks(3); check("loop_w1b", 32'(w), 32'(3'b001));
    check("loop_beats", 32'(beats), 32'd4);
    // SHORT / LONG
    sh = 1'b1;
    ticks(3); check("short_w1", 32'(w), 32'(3'b001));
    sh = 1'b0; lg = 1'b1;
    ticks(3); check("long_in_w1", 32'(w), 32'(3'b010));
    ticks(3); check("long_w3", 32'(w), 32'(3'b100));
    ticks(3); check("w3_to_w1", 32'(w), 32'(3'b001));
    sh = 1'b1;
    ticks(3); check("short_wins", 32'(w), 32'(3'b001));
    sh = 1'b0; lg = 1'b0;
    ticks(3); check("to_w2", 32'(w), 32'(3'b010));
    // STOP in W2
    stp = 1'b1;
    ticks(3);
    check("stop_state", 32'({run, w, t1, t2, t3}), 32'(7'b0_001_000));
    check("stop_beats", 32'(beats), 32'd11);
    stp = 1'b0;
    ticks(3);
    check("frozen_beats", 32'({run, beats}), 32'({1'b0, 16'd11}));
    // resume, with a press while running
    qd = 1'b1;
    ticks(2); check("resume_wait", 32'(run), 32'd0);
    tick();   check("resume", 32'({run, w, t1}), 32'(5'b1_001_1));
    lg = 1'b1;
    ticks(3); check("press_running", 32'({run, w, t1}), 32'(5'b1_010_1));
    qd = 1'b0;
    ticks(3); check("pre_clr_w3", 32'(w), 32'(3'b100));
    lg = 1'b0;
    tick();   check("pre_clr_t2", 32'({w, t2}), 32'(4'b100_1));
    // mid-beat reset with QD high during CLR
    clr = 1'b1; qd = 1'b1;
    tick();
    check("mid_clr", 32'({run, w, t1, t2, t3, beats}), 32'({7'b0_001_000, 16'd0}));
    tick();
    clr = 1'b0; qd = 1'b0;
    ticks(6); check("qd_forgotten", 32'(run), 32'd0);
`ifdef TIMING_STEP_EN
    step = 1'b1;
    qd = 1'b1; ticks(3); qd = 1'b0;
    check("step_run", 32'({run, t1}), 32'(2'b11));
    ticks(2); check("step_t3", 32'({run, t3}), 32'(2'b11));
    tick();   check("step_halt", 32'({run, w, beats}), 32'({4'b0_010, 16'd1}));
    ticks(3); check("step_stays", 32'(run), 32'd0);
    qd = 1'b1; ticks(3); qd = 1'b0;
    ticks(3); check("step_halt2", 32'({run, w, beats}), 32'({4'b0_001, 16'd2}));
    step = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Beat and phase generator sitting directly upstream of the hardwired controller.
- Produces the beat one-hot W[3:1] and the phase pulses T1/T2/T3 that the controller consumes.
- Takes back the controller's SHORT, LONG and STOP to shorten, lengthen or halt the instruction cycle.
- Started from the console start pushbutton QD.

Parameters:
- PHASES, 3, clock cycles per beat; legal range 3..8.
- CNT_W, 16, width of the completed-beat counter BEATS.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  reset; synchronous, active-high.
- QD  input  1  start pushbutton, asynchronous level; only its rising edge is used.
- SHORT  input  1  from controller; when sampled in W1, next beat is W1 again.
- LONG  input  1  from controller; when sampled in W2, next beat is W3.
- STOP  input  1  from controller; when sampled, halt after the current beat.
- W  output  3  beat one-hot, bit1=W1, bit2=W2, bit3=W3.
- T1  output  1  first phase of the current beat.
- T2  output  1  middle phase(s) of the current beat.
- T3  output  1  last phase of the current beat; controller state updates on its falling edge.
- RUN  output  1  generator running.
- BEATS  output  CNT_W  completed-beat count; wraps modulo 2^CNT_W.

Behaviour:
- Reset (CLR high at a rising edge):
  - RUN=0, W=3'b001, T1=T2=T3=0, phase counter p=0, BEATS=0.
  - QD synchronizer and edge registers are cleared.
  - Reset overrides every other event, including mid-beat.
- States: HALT (RUN=0) and RUNNING (RUN=1).
- In HALT:
  - T1..T3 are all 0; W holds its value; p=0.
- QD start path:
  - QD passes through two synchronizer flops (q1, q2) and a delay flop q3.
  - start = q2 & ~q3.
  - When start is seen in HALT, RUN is set at that edge.
  - Latency: QD sampled high at edge k gives RUN=1 and T1=1 after edge k+2.
  - start is ignored in RUNNING.
- In RUNNING, p counts 0..PHASES-1:
  - T1 = (p==0).
  - T3 = (p==PHASES-1).
  - T2 = (0<p<PHASES-1).
  - Exactly one of T1/T2/T3 is high each cycle.
- End-of-beat edge (RUNNING and p==PHASES-1):
  - p <= 0; BEATS <= BEATS+1.
  - SHORT, LONG and STOP are sampled at this edge only; their values in other phases are don't-care.
- Next W at the end-of-beat edge:
  - From W1: W1 if SHORT, else W2.
  - From W2: W3 if LONG, else W1.
  - From W3: W1.
  - SHORT is ignored outside W1; LONG is ignored outside W2.
  - If SHORT and LONG are both high in W1, SHORT wins.
- Halting:
  - If STOP is high at the end-of-beat edge, RUN <= 0 and W still advances per the rules above.
  - The next start resumes with that W.
  - If start and the halting edge coincide, halt wins and the start edge is dropped; QD must be re-pressed.
- W is always one-hot; any illegal W value is forced to 3'b001 at the next edge.
- BEATS counts every completed beat, including the one that halts.

Optional Feature:
- Macro TIMING_STEP_EN.
- When defined:
  - Adds input port STEP (1 bit).
  - With STEP=1, the generator halts at every end-of-beat edge as if STOP were high.
  - One QD press therefore runs exactly one beat.
  - STEP=0 behaves exactly as the base block.
- When undefined: no STEP port; halting is controlled only by STOP.

Test Plan:
- Reset/start: CLR high 2 cycles, then QD held high from edge 5 → RUN=0, W=001 until edge 6; RUN=1 and T1=1 after edge 7; T2 after edge 8; T3 after edge 9; W=010 after edge 10.
- Normal 2-beat loop, PHASES=3, SHORT=LONG=STOP=0 → W sequence 001,010,001,010; each beat is 3 cycles; BEATS=4 after 12 running cycles.
- SHORT and LONG:
  - SHORT=1 during W1 T3 → W stays 001.
  - LONG=1 during W2 T3 → W goes to 100, then 001.
  - SHORT=LONG=1 in W1 → W stays 001.
- STOP in W2 with LONG=0:
  - RUN drops at the end of W2; W=001; T1..T3=0; BEATS frozen.
  - A second QD press resumes at W1.
  - QD pressed while RUNNING has no effect.
- Mid-operation reset: CLR asserted at W3 T2 → next cycle RUN=0, W=001, BEATS=0; QD high during CLR is not remembered.
- TIMING_STEP_EN defined, STEP=1 → each QD press gives exactly 3 cycles of T1/T2/T3 and then RUN=0; BEATS increments by 1 per press.
